// File: rtl/g2x_ctrl_p_if.sv
// FIFO-read and XGMII-style output bus between the drain controller (master)
// and the byte-count/data FIFOs plus the downstream sink (slave).
interface g2x_ctrl_p_if #(
  parameter int DW     = 64,
  parameter int BCNT_W = 16
);
  localparam int CW = DW / 8;

  logic              bcnt_empty;
  logic [BCNT_W-1:0] bcnt_in;
  logic              bcnt_re;
  logic              data_empty;
  logic [DW-1:0]     data_in;
  logic [CW-1:0]     ctrl_in;
  logic              data_re;
  logic [DW-1:0]     data_out;
  logic [CW-1:0]     ctrl_out;
  logic              out_vld;

  modport master (
    input  bcnt_empty, bcnt_in, data_empty, data_in, ctrl_in,
    output bcnt_re, data_re, data_out, ctrl_out, out_vld
  );

  modport slave (
    output bcnt_empty, bcnt_in, data_empty, data_in, ctrl_in,
    input  bcnt_re, data_re, data_out, ctrl_out, out_vld
  );
endinterface

// File: rtl/g2x_ctrl_p.sv
// Receive-path drain controller: pops one byte count per packet, reads the
// matching number of words from the data FIFO and drives them onto an XGMII-style bus.
module g2x_ctrl_p #(
  parameter int          DW        = 64,
  parameter int          BCNT_W    = 16,
  parameter int          RD_LAT    = 2,
  parameter int          MIN_IPG   = 2,
  parameter int          MAX_WORDS = 1200,
  parameter logic [7:0]  IDLE_BYTE = 8'h07
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        en,
  g2x_ctrl_p_if.master bus,
  output logic        busy,
  output logic        err_zero,
  output logic        err_over,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt
);

  localparam int BPW = DW / 8;
  localparam int WW  = BCNT_W + 1;
  localparam int IW  = (MIN_IPG < 2) ? 1 : $clog2(MIN_IPG + 1);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    RD_BCNT  = 5'b00010,
    BCNT_BUF = 5'b00100,
    RD_DATA  = 5'b01000,
    IPG      = 5'b10000
  } state_t;

  state_t            state;
  logic [WW-1:0]     words_left;
  logic [IW-1:0]     ipg_cnt;
  logic              discard;
  logic              data_re_i;
  logic [RD_LAT-1:0] vld_pipe;

  logic              sof;
  logic [BCNT_W-2:0] len;
  logic [WW-1:0]     tot_bytes;
  logic [WW-1:0]     words;

  // A sof4 packet carries a 4-byte prefix that occupies data-FIFO space too.
  always_comb begin
    sof       = bus.bcnt_in[BCNT_W-1];
    len       = bus.bcnt_in[BCNT_W-2:0];
    tot_bytes = WW'(len) + (sof ? WW'(4) : WW'(0));
    words     = (tot_bytes + WW'(BPW - 1)) / WW'(BPW);
  end

  assign data_re_i   = (state == RD_DATA) && (words_left != '0) && !bus.data_empty;
  assign bus.data_re = data_re_i;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      bus.bcnt_re <= 1'b0;
      words_left  <= '0;
      ipg_cnt     <= '0;
      discard     <= 1'b0;
      err_zero    <= 1'b0;
      err_over    <= 1'b0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      err_zero <= 1'b0;
      err_over <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && !bus.bcnt_empty && (ipg_cnt == '0)) begin
            bus.bcnt_re <= 1'b1;
            state       <= RD_BCNT;
          end
        end
        RD_BCNT: begin
          bus.bcnt_re <= 1'b0;
          state       <= BCNT_BUF;
        end
        BCNT_BUF: begin
          if (len == '0) begin
            err_zero   <= 1'b1;
            drop_cnt   <= drop_cnt + 32'd1;
            words_left <= '0;
            ipg_cnt    <= IW'(MIN_IPG);
            state      <= IPG;
          end else if (words > WW'(MAX_WORDS)) begin
            // Oversize packets are still drained so the data FIFO stays aligned.
            err_over   <= 1'b1;
            drop_cnt   <= drop_cnt + 32'd1;
            discard    <= 1'b1;
            words_left <= words;
            state      <= RD_DATA;
          end else begin
            pkt_cnt    <= pkt_cnt + 32'd1;
            discard    <= 1'b0;
            words_left <= words;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (words_left == '0) begin
            ipg_cnt <= IW'(MIN_IPG);
            state   <= IPG;
          end else if (data_re_i) begin
            words_left <= words_left - WW'(1);
          end
        end
        IPG: begin
          if (ipg_cnt != '0) ipg_cnt <= ipg_cnt - IW'(1);
          if (ipg_cnt <= IW'(1)) state <= IDLE;
        end
        default: begin
          bus.bcnt_re <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Read-valid line tracks the FIFO read latency; the output register adds one more cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      vld_pipe     <= '0;
      bus.data_out <= {BPW{IDLE_BYTE}};
      bus.ctrl_out <= '1;
      bus.out_vld  <= 1'b0;
    end else begin
      vld_pipe[0] <= data_re_i && !discard;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (vld_pipe[RD_LAT-1]) begin
        bus.data_out <= bus.data_in;
        bus.ctrl_out <= bus.ctrl_in;
        bus.out_vld  <= 1'b1;
      end else begin
        bus.data_out <= {BPW{IDLE_BYTE}};
        bus.ctrl_out <= '1;
        bus.out_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_g2x_ctrl_p.sv
// Bench for g2x_ctrl_p: FIFO models, a packet-level scoreboard checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_g2x_ctrl_p;

  localparam int         DW        = 64;
  localparam int         CW        = DW / 8;
  localparam int         BPW       = DW / 8;
  localparam int         WDW       = DW + CW;
  localparam int         BCNT_W    = 16;
  localparam int         RD_LAT    = 2;
  localparam int         MIN_IPG   = 2;
  localparam int         MAX_WORDS = 1200;
  localparam logic [7:0] IDLE_BYTE = 8'h07;

  logic clk    = 1'b0;
  logic reset_ = 1'b1;
  logic en     = 1'b0;
  logic stall  = 1'b0;

  logic              bcnt_empty_r = 1'b1;
  logic              dq_empty     = 1'b1;
  logic [BCNT_W-1:0] bcnt_in_r    = '0;
  logic [DW-1:0]     din          = '0;
  logic [CW-1:0]     cin          = '0;

  logic        busy, err_zero, err_over;
  logic [31:0] pkt_cnt, drop_cnt;

  g2x_ctrl_p_if #(.DW(DW), .BCNT_W(BCNT_W)) bus ();

  assign bus.bcnt_empty = bcnt_empty_r;
  assign bus.bcnt_in    = bcnt_in_r;
  assign bus.data_empty = dq_empty | stall;
  assign bus.data_in    = din;
  assign bus.ctrl_in    = cin;

  g2x_ctrl_p #(
    .DW(DW), .BCNT_W(BCNT_W), .RD_LAT(RD_LAT), .MIN_IPG(MIN_IPG),
    .MAX_WORDS(MAX_WORDS), .IDLE_BYTE(IDLE_BYTE)
  ) dut (
    .clk(clk), .reset_(reset_), .en(en), .bus(bus),
    .busy(busy), .err_zero(err_zero), .err_over(err_over),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // FIFO contents and packet-level expectations
  logic [BCNT_W-1:0] bq[$];
  logic [WDW-1:0]    dq[$];
  logic [WDW-1:0]    expq[$];
  logic [WDW-1:0]    pd[RD_LAT];

  int errors = 0, checks = 0;
  int cycle = 0, reads = 0, bcnt_pulses = 0;
  int exp_pkt = 0, exp_drop = 0, exp_zero = 0, exp_over = 0, exp_reads = 0;
  int zero_seen = 0, over_seen = 0;
  int t_first_re = -1, t_last_re = -1, t_first_vld = -1, t_last_vld = -1, t_vld_n = 0;
  int last_re_cyc = 0, gap_last = 0, idle_run = 0, r0 = 0, b0 = 0;
  logic re_s = 1'b0, bre_s = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [WDW-1:0] rand_word();
    logic [WDW-1:0] w = '0;
    for (int k = 0; k < (WDW + 31) / 32; k++) w = (w << 32) | WDW'($urandom);
    return w;
  endfunction

  // Queue one packet in both FIFOs and record what the output must show for it.
  task automatic add_packet(input bit sof, input int len);
    int words;
    logic [WDW-1:0] w;
    words = (len + (sof ? 4 : 0) + BPW - 1) / BPW;
    bq.push_back({sof, (BCNT_W-1)'(len)});
    bcnt_empty_r = 1'b0;
    if (len == 0) begin
      exp_drop++;
      exp_zero++;
      return;
    end
    exp_reads += words;
    if (words <= MAX_WORDS) exp_pkt++;
    else begin
      exp_drop++;
      exp_over++;
    end
    for (int i = 0; i < words; i++) begin
      w = rand_word();
      dq.push_back(w);
      if (words <= MAX_WORDS) expq.push_back(w);
    end
    dq_empty = 1'b0;
  endtask

  // Per-cycle compare against the scoreboard plus protocol checks.
  task automatic checkOutput();
    cycle++;
    chk("bcnt_re_while_empty", bus.bcnt_re && bus.bcnt_empty, 0);
    chk("data_re_while_empty", bus.data_re && bus.data_empty, 0);
    if (bus.out_vld) begin
      if (expq.size() == 0) chk("unexpected_out_vld", bus.out_vld, 0);
      else chk("out_word", {bus.ctrl_out, bus.data_out}, expq.pop_front());
      if (t_first_vld < 0) t_first_vld = cycle;
      t_last_vld = cycle;
      t_vld_n++;
    end else begin
      chk("idle_fill", {bus.ctrl_out, bus.data_out}, {{CW{1'b1}}, {BPW{IDLE_BYTE}}});
    end
    if (err_zero) zero_seen++;
    if (err_over) over_seen++;
    if (bus.data_re) begin
      reads++;
      if (t_first_re < 0) t_first_re = cycle;
      t_last_re   = cycle;
      last_re_cyc = cycle;
    end
    if (bus.bcnt_re) begin
      bcnt_pulses++;
      gap_last = cycle - last_re_cyc;
    end
    if (!busy && bq.size() == 0) idle_run++;
    else idle_run = 0;
    re_s  = bus.data_re;
    bre_s = bus.bcnt_re;
  endtask

  task automatic fifo_update();
    if (bre_s && bq.size() > 0) bcnt_in_r = bq.pop_front();
    bcnt_empty_r = (bq.size() == 0);
    for (int i = RD_LAT - 1; i > 0; i--) pd[i] = pd[i-1];
    if (re_s && dq.size() > 0) pd[0] = dq.pop_front();
    else pd[0] = rand_word();
    {cin, din} = pd[RD_LAT-1];
    dq_empty = (dq.size() == 0);
    re_s  = 1'b0;
    bre_s = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); #1;
    checkOutput();
    @(posedge clk); #1;
    fifo_update();
  endtask

  task automatic applyStimulus(input int ncycles);
    for (int i = 0; i < ncycles; i++) tick();
  endtask

  task automatic start_test();
    t_first_re  = -1;
    t_last_re   = -1;
    t_first_vld = -1;
    t_last_vld  = -1;
    t_vld_n     = 0;
    r0          = reads;
    b0          = bcnt_pulses;
  endtask

  task automatic wait_reads(input int n, input string name);
    int k = 0;
    while (reads - r0 < n && k < 200) begin
      tick();
      k++;
    end
    if (reads - r0 < n) chk({name, "_read_timeout"}, reads - r0, n);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    idle_run = 0;
    while (idle_run < RD_LAT + 3 && n < budget) begin
      tick();
      n++;
    end
    if (idle_run < RD_LAT + 3) chk({name, "_drain_timeout"}, n, 0);
    chk({name, "_reads"}, reads, exp_reads);
    chk({name, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    chk({name, "_drop_cnt"}, drop_cnt, exp_drop);
    chk({name, "_err_zero_pulses"}, zero_seen, exp_zero);
    chk({name, "_err_over_pulses"}, over_seen, exp_over);
    chk({name, "_words_left_unsent"}, expq.size(), 0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_bcnt_re"}, bus.bcnt_re, 0);
    chk({name, "_data_re"}, bus.data_re, 0);
    chk({name, "_out_vld"}, bus.out_vld, 0);
    chk({name, "_data_out"}, bus.data_out, 64'h0707070707070707);
    chk({name, "_ctrl_out"}, bus.ctrl_out, 8'hFF);
    chk({name, "_errs"}, {err_zero, err_over}, 0);
    chk({name, "_pkt_cnt"}, pkt_cnt, 0);
    chk({name, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lens[3];
    int expw[3];
    lens = '{8, 12, 13};
    expw = '{2, 2, 3};
    for (int i = 0; i < RD_LAT; i++) pd[i] = '0;

    #1 reset_ = 1'b0;
    applyStimulus(2);
    check_reset_values("reset");
    reset_ = 1'b1;
    applyStimulus(2);

    $display("[TB] single 64-byte packet");
    start_test();
    add_packet(1'b0, 64);
    en = 1'b1;
    drain(200, "len64");
    chk("len64_data_re_count", reads - r0, 8);
    chk("len64_bcnt_pulses", bcnt_pulses - b0, 1);
    chk("len64_consecutive", t_last_re - t_first_re, 7);
    chk("len64_latency", t_first_vld - t_first_re, 3);
    chk("len64_vld_words", t_vld_n, 8);
    chk("len64_pkt_cnt_lit", pkt_cnt, 1);

    $display("[TB] sof4 packets");
    for (int i = 0; i < 3; i++) begin
      start_test();
      add_packet(1'b1, lens[i]);
      drain(200, "sof");
      chk("sof_words", reads - r0, expw[i]);
    end

    $display("[TB] data FIFO underflow stall");
    start_test();
    add_packet(1'b0, 64);
    wait_reads(3, "stall");
    stall = 1'b1;
    applyStimulus(3);
    stall = 1'b0;
    drain(200, "stall");
    chk("stall_data_re_count", reads - r0, 8);
    chk("stall_vld_words", t_vld_n, 8);
    chk("stall_vld_hole", (t_last_vld - t_first_vld + 1) - t_vld_n, 3);

    $display("[TB] zero-length packet");
    start_test();
    add_packet(1'b0, 0);
    drain(200, "zero");
    chk("zero_no_reads", reads - r0, 0);
    chk("zero_drop_cnt_lit", drop_cnt, 1);
    chk("zero_pulse_lit", zero_seen, 1);

    $display("[TB] oversize packet");
    start_test();
    add_packet(1'b0, (MAX_WORDS + 1) * BPW);
    drain(3000, "over");
    chk("over_reads_lit", reads - r0, 1201);
    chk("over_no_vld", t_vld_n, 0);
    chk("over_drop_cnt_lit", drop_cnt, 2);

    $display("[TB] back-to-back packets and gap");
    en = 1'b0;
    start_test();
    add_packet(1'b0, 16);
    add_packet(1'b0, 24);
    en = 1'b1;
    drain(200, "ipg");
    chk("ipg_reads", reads - r0, 5);
    chk("ipg_gap_lit", gap_last, 5);

    $display("[TB] enable dropped mid-packet");
    start_test();
    add_packet(1'b0, 64);
    add_packet(1'b0, 8);
    wait_reads(2, "en");
    en = 1'b0;
    applyStimulus(40);
    chk("en_first_completes", reads - r0, 8);
    chk("en_second_not_started", bcnt_pulses - b0, 1);
    chk("en_idle", busy, 0);
    en = 1'b1;
    drain(200, "en_resume");

    $display("[TB] reset during data read");
    start_test();
    add_packet(1'b0, 64);
    wait_reads(3, "rst");
    #2 reset_ = 1'b0;
    #1 check_reset_values("midreset");
    bq.delete();
    dq.delete();
    expq.delete();
    bcnt_empty_r = 1'b1;
    dq_empty     = 1'b1;
    exp_pkt = 0; exp_drop = 0; exp_zero = 0; exp_over = 0;
    exp_reads = 0; reads = 0; zero_seen = 0; over_seen = 0;
    applyStimulus(3);
    reset_ = 1'b1;
    applyStimulus(2);
    start_test();
    add_packet(1'b0, 24);
    drain(200, "recover");
    chk("recover_pkt_cnt_lit", pkt_cnt, 1);
    chk("recover_reads_lit", reads - r0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
